id_stage: RTL

- Instruction-decode stage, directly downstream of the fetch stage. Consumes its combinational if_id_regs_t output (inst, pc).
- Contains the IF/ID pipeline register, the 32x64 integer register file, RV64I decode and immediate generation, load-use hazard detection, and the ID/EX pipeline register.
- Drives the fetch-stage stall and feeds the execute stage through an id_ex_regs_t bundle.

---
 rtl/rv_pkg.sv | 87 ++++++++
 rtl/id_stage_reg_file.sv | 41 ++++
 rtl/id_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV64I pipeline types and constants.
//   if_id_regs_t  - fetch-stage output bundle (inst, pc)
//   id_ex_regs_t  - decode-stage output bundle feeding execute
//   op_class_e    - decoded instruction class
//   OPC_*         - major opcode encodings, NOP_INST - canonical addi x0,x0,0
//   imm_*()       - immediate extractors, sign-extended to 64 bits
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // CLS_NONE doubles as the bubble/illegal class so an all-zero bundle is inert.
  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OP_IMM,
    CLS_OP,
    CLS_OP_IMM_32,
    CLS_OP_32
  } op_class_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } if_id_regs_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7_b5;
    op_class_e   op_class;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_imm;
    logic        is_word;
    logic        illegal;
  } id_ex_regs_t;

  function automatic logic [63:0] imm_i(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [63:0] imm_s(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [63:0] imm_b(input logic [31:0] inst);
    return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u(input logic [31:0] inst);
    return {{32{inst[31]}}, inst[31:12], 12'b0};
  endfunction

  function automatic logic [63:0] imm_j(input logic [31:0] inst);
    return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// reg_file: 32x64 integer register file, 2 combinational read ports, 1 write port.
//   clk              - write clock (rising edge)
//   rs1, rs2         - read addresses
//   rs1_data/rs2_data- read data; x0 reads 0, same-cycle write is bypassed
//   we, rd, rd_data  - write port; writes to x0 are dropped
// The array has no reset.
module reg_file (
  input  logic        clk,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [63:0] rd_data
);

  logic [63:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && rd != '0) begin
      regs[rd] <= rd_data;
    end
  end

  // Write-through: a value being written this cycle is visible to decode now.
  always_comb begin
    rs1_data = '0;
    if (rs1 != '0) begin
      rs1_data = (we && rd == rs1) ? rd_data : regs[rs1];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2 != '0) begin
      rs2_data = (we && rd == rs2) ? rd_data : regs[rs2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV64I instruction-decode stage.
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_if_id_regs      - fetched inst/pc from the fetch stage
//   i_flush           - taken branch/jump in EX, kill younger instructions
//   i_ex_mem_read     - instruction in EX is a load
//   i_ex_rd           - destination register of the instruction in EX
//   i_wb_we/rd/data   - register-file writeback port
//   o_stall           - load-use hazard, drives the fetch-stage stall
//   o_id_ex_regs      - registered decoded bundle for execute
module id_stage
  import rv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  if_id_regs_t i_if_id_regs,
  input  logic        i_flush,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [63:0] i_wb_data,
  output logic        o_stall,
  output id_ex_regs_t o_id_ex_regs
);

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [63:0] pc;
  } if_id_q_t;

  if_id_q_t    if_id_q;
  id_ex_regs_t id_ex_d;
  id_ex_regs_t id_ex_q;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;

  op_class_e   op_class;
  logic        legal;
  logic        rs1_used;
  logic        rs2_used;
  logic        reg_we;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src_imm;
  logic        is_word;
  logic [63:0] imm;

  // IF/ID register
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      if_id_q.valid <= 1'b0;
      if_id_q.inst  <= NOP_INST;
      if_id_q.pc    <= RESET_PC;
    end else if (!o_stall) begin
      if_id_q.valid <= 1'b1;
      if_id_q.inst  <= i_if_id_regs.inst;
      if_id_q.pc    <= i_if_id_regs.pc;
    end
  end

  assign inst   = if_id_q.inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  reg_file u_reg_file (
    .clk      (i_clk),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (i_wb_we),
    .rd       (i_wb_rd),
    .rd_data  (i_wb_data)
  );

  // Decode and immediate generation
  always_comb begin
    op_class    = CLS_NONE;
    legal       = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    reg_we      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    is_word     = 1'b0;
    imm         = '0;

    case (opcode)
      OPC_LUI: begin
        op_class    = CLS_LUI;
        legal       = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_u(inst);
      end
      OPC_AUIPC: begin
        op_class    = CLS_AUIPC;
        legal       = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_u(inst);
      end
      OPC_JAL: begin
        op_class    = CLS_JAL;
        legal       = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_j(inst);
      end
      OPC_JALR: begin
        op_class    = CLS_JALR;
        legal       = (funct3 == 3'b000);
        rs1_used    = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_i(inst);
      end
      OPC_BRANCH: begin
        op_class = CLS_BRANCH;
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_b(inst);
      end
      OPC_LOAD: begin
        op_class    = CLS_LOAD;
        legal       = (funct3 != 3'b111);
        rs1_used    = 1'b1;
        reg_we      = 1'b1;
        mem_read    = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_i(inst);
      end
      OPC_STORE: begin
        op_class    = CLS_STORE;
        legal       = (funct3[2] == 1'b0);
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_s(inst);
      end
      OPC_OP_IMM: begin
        op_class    = CLS_OP_IMM;
        rs1_used    = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm         = imm_i(inst);
        // RV64 shifts carry a 6-bit shamt, so only inst[31:26] is the funct field.
        case (funct3)
          3'b001:  legal = (inst[31:26] == 6'b000000);
          3'b101:  legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        op_class = CLS_OP;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        reg_we   = 1'b1;
        legal    = (funct7 == FUNCT7_BASE) ||
                   ((funct7 == FUNCT7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM_32: begin
        op_class    = CLS_OP_IMM_32;
        rs1_used    = 1'b1;
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        is_word     = 1'b1;
        imm         = imm_i(inst);
        case (funct3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = (funct7 == FUNCT7_BASE);
          3'b101:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        op_class = CLS_OP_32;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        reg_we   = 1'b1;
        is_word  = 1'b1;
        case (funct3)
          3'b000:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          3'b001:  legal = (funct7 == FUNCT7_BASE);
          3'b101:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // An illegal instruction must not write state nor create a hazard.
    if (!legal) begin
      op_class    = CLS_NONE;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
      reg_we      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      alu_src_imm = 1'b0;
      is_word     = 1'b0;
    end
  end

  // Load-use hazard; a flush overrides it so the redirect is not held off.
  assign o_stall = if_id_q.valid && i_ex_mem_read && (i_ex_rd != '0) &&
                   ((rs1_used && rs1 == i_ex_rd) || (rs2_used && rs2 == i_ex_rd)) &&
                   !i_flush;

  always_comb begin
    id_ex_d             = '0;
    id_ex_d.valid       = if_id_q.valid;
    id_ex_d.pc          = if_id_q.pc;
    id_ex_d.rs1_data    = rs1_data;
    id_ex_d.rs2_data    = rs2_data;
    id_ex_d.imm         = imm;
    id_ex_d.rs1         = rs1;
    id_ex_d.rs2         = rs2;
    id_ex_d.rd          = rd;
    id_ex_d.funct3      = funct3;
    id_ex_d.funct7_b5   = inst[30];
    id_ex_d.op_class    = op_class;
    id_ex_d.reg_we      = reg_we;
    id_ex_d.mem_read    = mem_read;
    id_ex_d.mem_write   = mem_write;
    id_ex_d.alu_src_imm = alu_src_imm;
    id_ex_d.is_word     = is_word;
    id_ex_d.illegal     = !legal;
  end

  // ID/EX register
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush || o_stall) begin
      id_ex_q    <= '0;
      id_ex_q.pc <= RESET_PC;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign o_id_ex_regs = id_ex_q;

endmodule
